// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, baud divisor and
// sizing helpers. The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

  // Transmitter FSM states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } tx_state_e;

`ifdef UART_TX_PARITY_EN
  localparam int unsigned PARITY_BITS = 1;
`else
  localparam int unsigned PARITY_BITS = 0;
`endif

  // Clock cycles per line bit, integer-truncated
  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input int unsigned baudrate);
    return clk_freq / baudrate;
  endfunction

  // Clock cycles for one complete frame
  function automatic int unsigned frame_cycles(input int unsigned div,
                                               input int unsigned data_width,
                                               input int unsigned stop_bits);
    return (1 + data_width + PARITY_BITS + stop_bits) * div;
  endfunction

  // Width of an occupancy counter able to hold 0..depth
  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous active-low flush. Pushes are dropped
// when full and pops when empty; dout always presents the head entry.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];
  assign count   = cnt_q;

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset; a flush only clears the pointers
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO ahead of a start/data/[parity]/stop shifter
// paced by a single-clock baud counter. Frames go out back-to-back while
// words are queued. Optional parity stage: define UART_TX_PARITY_EN.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ      = 50000000,
  parameter int unsigned BAUDRATE      = 9600,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned STOP_BIT_SIZE = 1,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned PARITY_ODD    = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic [DATA_WIDTH-1:0]       in_data,
  output logic                        in_ready,
  output logic                        line,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int unsigned DIV = baud_div(CLK_FREQ, BAUDRATE);
  localparam int unsigned BW  = $clog2(DIV);
  localparam int unsigned IW  = $clog2(DATA_WIDTH);

  // Reject unsupported configurations at elaboration
  if (DIV < 2 || DATA_WIDTH < 5 || DATA_WIDTH > 9 || STOP_BIT_SIZE < 1 ||
      STOP_BIT_SIZE > 2 || FIFO_DEPTH < 2 || PARITY_ODD > 1 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_cfg_check
    $error("uart_tx_fifo: unsupported parameter set");
  end

  tx_state_e             state_q, state_d;
  logic                  line_q, line_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [IW-1:0]         bit_q, bit_d;
  logic                  stop_q, stop_d;
`ifdef UART_TX_PARITY_EN
  logic                  parity_q, parity_d;
`endif
  logic [BW-1:0]         baud_q;
  logic                  tick;
  logic                  pop;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  fifo_full;
  logic                  fifo_empty;

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid),
    .din   (in_data),
    .pop   (pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign in_ready = !fifo_full;
  assign busy     = (state_q != ST_IDLE) || !fifo_empty;
  assign line     = line_q;
  assign tick     = (baud_q == BW'(DIV - 1));

  // Bit-period counter; restarts on every frame start so the start bit is a full period
  always_ff @(posedge clk) begin
    if (!rst_n || pop || state_q == ST_IDLE || tick) baud_q <= '0;
    else                                             baud_q <= baud_q + BW'(1);
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      line_q   <= 1'b1;
      shift_q  <= '0;
      bit_q    <= '0;
      stop_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      line_q   <= line_d;
      shift_q  <= shift_d;
      bit_q    <= bit_d;
      stop_q   <= stop_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Next-state, next-line and FIFO pop decisions
  always_comb begin
    state_d  = state_q;
    line_d   = line_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    stop_d   = stop_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    pop      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_head;
`ifdef UART_TX_PARITY_EN
          parity_d = (^fifo_head) ^ 1'(PARITY_ODD);
`endif
          line_d  = 1'b0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          line_d  = shift_q[0];
          shift_d = shift_q >> 1;
          bit_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_q == IW'(DATA_WIDTH - 1)) begin
`ifdef UART_TX_PARITY_EN
            line_d  = parity_q;
            state_d = ST_PARITY;
`else
            line_d  = 1'b1;
            stop_d  = 1'b0;
            state_d = ST_STOP;
`endif
          end else begin
            line_d  = shift_q[0];
            shift_d = shift_q >> 1;
            bit_d   = bit_q + IW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          line_d  = 1'b1;
          stop_d  = 1'b0;
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          if (stop_q == 1'(STOP_BIT_SIZE - 1)) begin
            // Chain straight into the next frame when more data is queued
            if (!fifo_empty) begin
              pop     = 1'b1;
              shift_d = fifo_head;
`ifdef UART_TX_PARITY_EN
              parity_d = (^fifo_head) ^ 1'(PARITY_ODD);
`endif
              line_d  = 1'b0;
              state_d = ST_START;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: begin
        line_d  = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at DIV=10 (1 MHz clock, 100 kbaud).
// Four instances: 8N1, 8 data + 2 stop, 7 data bits, and odd parity.
module tb_uart_tx_fifo;

`ifdef UART_TX_PARITY_EN
  localparam int P       = 1;
  localparam int PAR_EVN = 1;  // even parity of 0x07
  localparam int PAR_ODD = 0;
`else
  localparam int P       = 0;
  localparam int PAR_EVN = 1;  // stop bit in that slot
  localparam int PAR_ODD = 1;
`endif
  localparam int L8 = (10 + P) * 10;  // 8-bit, 1-stop frame length

  logic       clk;
  logic       rst_n;
  logic       v0, v1, v2, v3;
  logic [7:0] d0, d1, d3;
  logic [6:0] d2;
  logic       r0, r1, r2, r3;
  logic       l0, l1, l2, l3;
  logic       b0, b1, b2, b3;
  logic [2:0] c0, c1, c2, c3;

  int n_pass  = 0;
  int n_total = 0;

  uart_tx_fifo #(.CLK_FREQ(1000000), .BAUDRATE(100000)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_data(d0), .in_ready(r0),
    .line(l0), .busy(b0), .fifo_count(c0));

  uart_tx_fifo #(.CLK_FREQ(1000000), .BAUDRATE(100000), .STOP_BIT_SIZE(2)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_data(d1), .in_ready(r1),
    .line(l1), .busy(b1), .fifo_count(c1));

  uart_tx_fifo #(.CLK_FREQ(1000000), .BAUDRATE(100000), .DATA_WIDTH(7)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_data(d2), .in_ready(r2),
    .line(l2), .busy(b2), .fifo_count(c2));

  uart_tx_fifo #(.CLK_FREQ(1000000), .BAUDRATE(100000), .PARITY_ODD(1)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_data(d3), .in_ready(r3),
    .line(l3), .busy(b3), .fifo_count(c3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance n clock edges; sample and drive 1 time unit after each edge
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  initial begin
    logic [7:0] bits;
    logic [7:0] raw;
    logic [7:0] words;
    int highs;

    rst_n = 1'b0;
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0; v3 = 1'b0;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;
    step(2);

    // Reset state
    check("rst line0", 32'(l0), 1);
    check("rst busy0", 32'(b0), 0);
    check("rst ready0", 32'(r0), 1);
    check("rst count0", 32'(c0), 0);
    check("rst ready1", 32'(r1), 1);
    check("rst count1", 32'(c1), 0);
    check("rst ready2", 32'(r2), 1);
    check("rst count2", 32'(c2), 0);
    check("rst ready3", 32'(r3), 1);
    check("rst count3", 32'(c3), 0);
    rst_n = 1'b1;
    step(1);

    // Test 1: single 0xA5 frame, 8N1
    v0 = 1'b1; d0 = 8'hA5;
    step(1);                              // edge 0
    v0 = 1'b0;
    check("t1 count after push", 32'(c0), 1);
    check("t1 line idle at edge0", 32'(l0), 1);
    check("t1 busy at edge0", 32'(b0), 1);
    step(1);                              // edge 1
    check("t1 start first", 32'(l0), 0);
    step(9);                              // edge 10
    check("t1 start last", 32'(l0), 0);
    bits = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      step(1);
      check($sformatf("t1 bit%0d first", i), 32'(l0), 32'(bits[i]));
      step(9);
      check($sformatf("t1 bit%0d last", i), 32'(l0), 32'(bits[i]));
    end
`ifdef UART_TX_PARITY_EN
    step(1);
    check("t1 parity", 32'(l0), 0);
    step(9);
`endif
    step(1);
    check("t1 stop first", 32'(l0), 1);
    step(9);
    check("t1 stop last", 32'(l0), 1);
    check("t1 busy before end", 32'(b0), 1);
    step(1);
    check("t1 busy falls", 32'(b0), 0);
    check("t1 line idle", 32'(l0), 1);

    // Test 3: parity of 0x07, even on u0 and odd on u3
    do_reset();
    v0 = 1'b1; d0 = 8'h07;
    v3 = 1'b1; d3 = 8'h07;
    step(1);                              // edge 0
    v0 = 1'b0; v3 = 1'b0;
    step(91);                             // edge 91
    check("t3 parity even", 32'(l0), PAR_EVN);
    check("t3 parity odd", 32'(l3), PAR_ODD);
    step(9 + 10 * P);                     // edge L8
    check("t3 busy at end", 32'(b0), 1);
    step(1);
    check("t3 busy falls even", 32'(b0), 0);
    check("t3 busy falls odd", 32'(b3), 0);

    // Test 2: six-cycle burst into a depth-4 FIFO
    do_reset();
    v0 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      d0 = 8'(k + 1);
      step(1);                            // edges 0..4
    end
    check("t2 count peak", 32'(c0), 4);
    check("t2 ready low when full", 32'(r0), 0);
    d0 = 8'd6;
    step(1);                              // edge 5
    v0 = 1'b0;
    check("t2 sixth rejected", 32'(c0), 4);
    words = 8'b0001_0101;                 // bit0 of words 1..5 -> index j
    step(L8 - 5);                         // edge L8
    for (int j = 1; j <= 4; j++) begin
      check($sformatf("t2 line before start%0d", j), 32'(l0), 1);
      check($sformatf("t2 count before start%0d", j), 32'(c0), 32'(5 - j));
      step(1);
      check($sformatf("t2 start%0d", j), 32'(l0), 0);
      check($sformatf("t2 count after start%0d", j), 32'(c0), 32'(4 - j));
      step(10);
      check($sformatf("t2 word%0d bit0", j + 1), 32'(l0), 32'(words[j]));
      step(L8 - 11);
    end
    check("t2 busy last frame", 32'(b0), 1);
    step(1);
    check("t2 busy falls", 32'(b0), 0);
    check("t2 ready restored", 32'(r0), 1);

    // Test 4: two stop bits, two 0x00 words queued
    do_reset();
    v1 = 1'b1; d1 = 8'h00;
    step(2);                              // edges 0, 1
    v1 = 1'b0;
    check("t4 count push+pop", 32'(c1), 1);
    check("t4 first start", 32'(l1), 0);
    step(89 + 10 * P);                    // edge 90+10P
    check("t4 last data low", 32'(l1), 0);
    step(1);
    check("t4 stop first", 32'(l1), 1);
    step(19);
    check("t4 stop last", 32'(l1), 1);
    check("t4 busy", 32'(b1), 1);
    step(1);
    check("t4 second start", 32'(l1), 0);
    check("t4 count drained", 32'(c1), 0);

    // Test 5: reset mid-frame with words queued
    do_reset();
    v0 = 1'b1; d0 = 8'h00;
    step(3);                              // edges 0..2
    v0 = 1'b0;
    step(42);                             // edge 44
    check("t5 count queued", 32'(c0), 2);
    check("t5 line mid data", 32'(l0), 0);
    rst_n = 1'b0;
    step(1);                              // edge 45
    check("t5 line after rst", 32'(l0), 1);
    check("t5 busy after rst", 32'(b0), 0);
    check("t5 count after rst", 32'(c0), 0);
    check("t5 ready after rst", 32'(r0), 1);
    rst_n = 1'b1;
    highs = 0;
    repeat (500) begin
      step(1);
      if (l0 === 1'b1) highs++;
    end
    check("t5 line idle 500", 32'(highs), 500);
    check("t5 busy idle", 32'(b0), 0);

    // Test 6: 7-bit data, 0xFF truncated to 0x7F
    do_reset();
    raw = 8'hFF;
    v2 = 1'b1; d2 = raw[6:0];
    step(1);                              // edge 0
    v2 = 1'b0;
    step(1);
    check("t6 start first", 32'(l2), 0);
    step(9);
    check("t6 start last", 32'(l2), 0);
    highs = 0;
    repeat (80 + 10 * P) begin
      step(1);
      if (l2 === 1'b1) highs++;
    end
    check("t6 ones and stop", 32'(highs), 32'(80 + 10 * P));
    check("t6 busy at end", 32'(b2), 1);
    step(1);
    check("t6 busy falls", 32'(b2), 0);
    check("t6 line idle", 32'(l2), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
